lkp_tx_arbiter: RTL

- Packet-level round-robin arbiter that shares the single UDP tx stream between N reply sources: lookup-reply parser, set/ack generator, error responder.
- Each source presents a 512-bit stream with tkeep/tlast plus size/src/dst sideband.
- Once granted, a source owns the output until its tlast beat is accepted, so beats from different sources never interleave.
- Sits between the reply sources and the UDP tx engine, with one registered output stage.

---
 rtl/lkp_pkg.sv | 21 ++
 rtl/lkp_tx_arbiter_rr_pick.sv | 28 ++
 rtl/lkp_tx_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lkp_pkg.sv
// Shared types and constants for the lookup-engine reply path.
package lkp_pkg;

  localparam int DATA_W       = 512;
  localparam int KEEP_W       = DATA_W / 8;
  localparam int HEADER_BYTES = 11;

  localparam logic [15:0] TX_DST_HOST = 16'h0040;

  typedef struct packed {
    logic [15:0] size;
    logic [15:0] src;
    logic [15:0] dst;
  } tx_side_t;

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } arb_state_t;

endpackage

// File: rtl/lkp_tx_arbiter_rr_pick.sv
// Combinational N-way round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int idx;

  // Scan from the farthest candidate back to ptr so the closest one wins.
  always_comb begin
    gnt_idx = '0;
    idx     = 0;
    any     = |req;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) gnt_idx = IDX_W'(idx);
    end
    gnt_onehot = any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/lkp_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UDP tx stream between N reply sources.
module lkp_tx_arbiter
  import lkp_pkg::*;
#(
  parameter int N         = 3,
  parameter int DATA_W    = lkp_pkg::DATA_W,
  parameter bit STAMP_SRC = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N-1:0]                s_axis_tvalid,
  input  logic [N*DATA_W-1:0]         s_axis_tdata,
  input  logic [N*DATA_W/8-1:0]       s_axis_tkeep,
  input  logic [N-1:0]                s_axis_tlast,
  input  logic [N*16-1:0]             s_axis_size,
  input  logic [N*16-1:0]             s_axis_src,
  input  logic [N*16-1:0]             s_axis_dst,
  output logic [N-1:0]                s_axis_tready,
  output logic                        m_axis_tx_tvalid,
  output logic [DATA_W-1:0]           m_axis_tx_tdata,
  output logic [DATA_W/8-1:0]         m_axis_tx_tkeep,
  output logic                        m_axis_tx_tlast,
  output logic [15:0]                 m_axis_tx_size,
  output logic [15:0]                 m_axis_tx_src,
  output logic [15:0]                 m_axis_tx_dst,
  input  logic                        m_axis_tx_tready,
  output logic [$clog2(N)-1:0]        grant_idx,
  output logic                        busy
);

  localparam int IDX_W = $clog2(N);
  localparam int KW    = DATA_W / 8;

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic             armed;
  tx_side_t         side;

  logic [N-1:0]     pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic [IDX_W-1:0] sel;
  logic             sel_valid;
  logic             sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [KW-1:0]    sel_keep;
  tx_side_t         side_in;
  logic             slot_free;
  logic             fire;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == N - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (s_axis_tvalid),
    .ptr        (rr_ptr),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  assign slot_free = !m_axis_tx_tvalid || m_axis_tx_tready;
  assign sel       = (state == ST_LOCK) ? grant_idx : pick_idx;
  assign sel_valid = s_axis_tvalid[sel];
  assign sel_last  = s_axis_tlast[sel];
  assign sel_data  = s_axis_tdata[int'(sel)*DATA_W +: DATA_W];
  assign sel_keep  = s_axis_tkeep[int'(sel)*KW +: KW];
  assign fire      = armed && slot_free && sel_valid;

  assign side_in.size = s_axis_size[int'(sel)*16 +: 16];
  assign side_in.src  = STAMP_SRC ? 16'(sel) : s_axis_src[int'(sel)*16 +: 16];
  assign side_in.dst  = s_axis_dst[int'(sel)*16 +: 16];

  // armed keeps every tready low until the first clock after reset release.
  always_comb begin
    s_axis_tready = '0;
    if (armed && slot_free) begin
      if (state == ST_LOCK) begin
        s_axis_tready[grant_idx] = 1'b1;
      end else if (pick_any) begin
        s_axis_tready = pick_onehot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      rr_ptr           <= '0;
      grant_idx        <= '0;
      busy             <= 1'b0;
      armed            <= 1'b0;
      side             <= '0;
      m_axis_tx_tvalid <= 1'b0;
      m_axis_tx_tdata  <= '0;
      m_axis_tx_tkeep  <= '0;
      m_axis_tx_tlast  <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (fire) begin
        m_axis_tx_tvalid <= 1'b1;
        m_axis_tx_tdata  <= sel_data;
        m_axis_tx_tkeep  <= sel_keep;
        m_axis_tx_tlast  <= sel_last;
        // Sideband belongs to the first beat; later beats leave it untouched.
        if (state == ST_IDLE) side <= side_in;
        if (sel_last) begin
          state  <= ST_IDLE;
          rr_ptr <= next_idx(sel);
          busy   <= 1'b0;
        end else begin
          state     <= ST_LOCK;
          grant_idx <= sel;
          busy      <= 1'b1;
        end
      end else if (m_axis_tx_tready) begin
        m_axis_tx_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tx_size = side.size;
  assign m_axis_tx_src  = side.src;
  assign m_axis_tx_dst  = side.dst;

endmodule
